// File: rtl/rstseq_pkg.sv
// rstseq_pkg: shared types and constants for the RN/SETN release sequencer.
//   - rstseq_state_e : sequencer state, binary encoded
//   - CNT_W_DEFAULT  : default hold counter width
//   - HOLD_CYCLES_DEFAULT / HOLD_TC_DEFAULT : default hold length and its terminal count
//   - hold_tc()      : terminal count for a given hold length
package rstseq_pkg;

    typedef enum logic [2:0] {
        StRstHold = 3'd0,
        StIdle    = 3'd1,
        StClrHold = 3'd2,
        StSetHold = 3'd3,
        StGuard   = 3'd4,
        StDone    = 3'd5
    } rstseq_state_e;

    localparam int unsigned CNT_W_DEFAULT       = 4;
    localparam int unsigned HOLD_CYCLES_DEFAULT = 8;
    localparam int unsigned HOLD_TC_DEFAULT     = HOLD_CYCLES_DEFAULT - 1;

    // Counter value at which a hold is complete.
    function automatic int unsigned hold_tc(input int unsigned hold_cycles);
        return hold_cycles - 1;
    endfunction

endpackage

// File: rtl/rstset_release_seq_if.sv
// rstset_release_seq_if: request/control bundle of the release sequencer.
//   req_clr : software clear request (master -> slave)
//   req_set : software preset request (master -> slave)
//   rn      : active-low clear to the flop bank (slave -> master)
//   setn    : active-low preset to the flop bank (slave -> master)
//   busy    : sequencer not idle (slave -> master)
//   ack     : one-cycle completion pulse for a software request (slave -> master)
interface rstset_release_seq_if;

    logic req_clr;
    logic req_set;
    logic rn;
    logic setn;
    logic busy;
    logic ack;

    modport master (
        output req_clr,
        output req_set,
        input  rn,
        input  setn,
        input  busy,
        input  ack
    );

    modport slave (
        input  req_clr,
        input  req_set,
        output rn,
        output setn,
        output busy,
        output ack
    );

endinterface

// File: rtl/rstseq_sync.sv
// rstseq_sync: reset-deassertion synchronizer. A SYNC_STAGES-deep chain cleared
// asynchronously by rst_i that shifts in a constant 1.
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset, clears the chain
//   sync_o : last stage of the chain
module rstseq_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic sync_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rstset_release_seq.sv
// rstset_release_seq: drives RN/SETN of a negative-edge async-clear/preset flop bank.
// Controls assert asynchronously on rst_i and are released on the rising clk_i edge
// after a programmable hold; software clear/preset pulses run with a busy/ack handshake.
//   clk_i  : clock, all state changes on the rising edge
//   rst_i  : asynchronous active-high reset
//   bus_if : slave side of rstset_release_seq_if (req_clr, req_set, rn, setn, busy, ack)
// Optional feature: define RSTSEQ_SETN_EN to build the preset path (SET_HOLD,
// req_set honoured, setn driven). Without it setn is tied high and req_set ignored.
module rstset_release_seq
    import rstseq_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
    parameter int unsigned CNT_W       = CNT_W_DEFAULT
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    rstset_release_seq_if.slave  bus_if
);

    localparam logic [CNT_W-1:0] HoldTc = CNT_W'(hold_tc(HOLD_CYCLES));

    rstseq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             rn_q, rn_d;
    logic             ack_q, ack_d;
    logic             sync_out;

`ifdef RSTSEQ_SETN_EN
    logic             setn_q, setn_d;
`else
    logic             unused_req_set;
    assign unused_req_set = bus_if.req_set;
`endif

    rstseq_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .sync_o (sync_out)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tc_d    = 1'b0;
        rn_d    = rn_q;
        ack_d   = 1'b0;
`ifdef RSTSEQ_SETN_EN
        setn_d  = setn_q;
`endif
        case (state_q)
            StRstHold: begin
                rn_d = 1'b0;
`ifdef RSTSEQ_SETN_EN
                setn_d = 1'b1;
`endif
                // Count only once the synchronised release has arrived.
                if (sync_out) begin
                    if (cnt_q == HoldTc) begin
                        rn_d    = 1'b1;
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            StIdle: begin
                cnt_d = '0;
                if (bus_if.req_clr) begin
                    rn_d    = 1'b0;
                    state_d = StClrHold;
                end
`ifdef RSTSEQ_SETN_EN
                else if (bus_if.req_set) begin
                    setn_d  = 1'b0;
                    state_d = StSetHold;
                end
`endif
            end
            // Terminal count is registered (tc_q), so the control stays low through
            // edge k+HOLD_CYCLES and is released one edge later.
            StClrHold: begin
                if (tc_q) begin
                    rn_d    = 1'b1;
                    state_d = StGuard;
                    cnt_d   = '0;
                end else begin
                    tc_d = (cnt_q == HoldTc);
                    if (cnt_q != HoldTc) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`ifdef RSTSEQ_SETN_EN
            StSetHold: begin
                if (tc_q) begin
                    setn_d  = 1'b1;
                    state_d = StGuard;
                    cnt_d   = '0;
                end else begin
                    tc_d = (cnt_q == HoldTc);
                    if (cnt_q != HoldTc) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
`endif
            StGuard: begin
                ack_d   = 1'b1;
                state_d = StDone;
                cnt_d   = '0;
            end
            StDone: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
            default: begin
                // Unreachable codes fall back to a full release sequence.
                rn_d    = 1'b0;
                state_d = StRstHold;
                cnt_d   = '0;
`ifdef RSTSEQ_SETN_EN
                setn_d  = 1'b1;
`endif
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StRstHold;
            cnt_q   <= '0;
            tc_q    <= 1'b0;
            rn_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tc_q    <= tc_d;
            rn_q    <= rn_d;
            ack_q   <= ack_d;
        end
    end

`ifdef RSTSEQ_SETN_EN
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            setn_q <= 1'b1;
        end else begin
            setn_q <= setn_d;
        end
    end
    assign bus_if.setn = setn_q;
`else
    assign bus_if.setn = 1'b1;
`endif

    assign bus_if.rn   = rn_q;
    assign bus_if.ack  = ack_q;
    assign bus_if.busy = (state_q != StIdle);

endmodule

// File: tb/tb_rstset_release_seq.sv
// tb_rstset_release_seq: directed + randomized stimulus for rstset_release_seq, checked
// every cycle against an edge-count timing model of the release and request sequences.
module tb_rstset_release_seq;

    localparam int S = 2;
    localparam int H = 8;
`ifdef RSTSEQ_SETN_EN
    localparam bit SetEn = 1'b1;
`else
    localparam bit SetEn = 1'b0;
`endif

    logic clk;
    logic rst;

    rstset_release_seq_if bus_if ();

    rstset_release_seq #(
        .SYNC_STAGES(S),
        .HOLD_CYCLES(H),
        .CNT_W      (4)
    ) u_dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // Model: e_rel = edges since reset release, op_kind 0 none / 1 clear / 2 preset,
    // op_k = edge at which the current request was accepted.
    int e_rel;
    int op_k;
    int op_kind;

    task automatic check_eq(input string tag, input logic obs, input logic exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        logic r, c, s;
        int   d;
        logic rel, exp_rn, exp_setn, exp_busy, exp_ack;
        r = rst;
        c = bus_if.req_clr;
        s = bus_if.req_set;
        if (r) begin
            e_rel   = 0;
            op_kind = 0;
        end else begin
            e_rel++;
            // A request is sampled only in IDLE: after release and H+4 edges after the last one.
            if (op_kind != 0 && e_rel - op_k >= H + 4) op_kind = 0;
            if (op_kind == 0 && e_rel >= S + H + 1) begin
                if (c) begin
                    op_kind = 1;
                    op_k    = e_rel;
                end else if (s && SetEn) begin
                    op_kind = 2;
                    op_k    = e_rel;
                end
            end
        end
        d        = e_rel - op_k;
        rel      = !r && (e_rel >= S + H);
        exp_rn   = rel && !(op_kind == 1 && d <= H);
        exp_setn = !(op_kind == 2 && d <= H);
        exp_busy = !rel || (op_kind != 0 && d <= H + 2);
        exp_ack  = (op_kind != 0) && (d == H + 2);
        #1;
        check_eq("rn", bus_if.rn, exp_rn);
        check_eq("setn", bus_if.setn, exp_setn);
        check_eq("busy", bus_if.busy, exp_busy);
        check_eq("ack", bus_if.ack, exp_ack);
        check_eq("never_both_low", bus_if.rn | bus_if.setn, 1'b1);
    end

    assert property (@(posedge clk) (bus_if.rn || bus_if.setn))
        else $error("rn and setn both low");

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        e_rel          = 0;
        op_k           = 0;
        op_kind        = 0;
        rst            = 1'b1;
        bus_if.req_clr = 1'b0;
        bus_if.req_set = 1'b0;

        #1;
        check_eq("reset_rn", bus_if.rn, 1'b0);
        check_eq("reset_setn", bus_if.setn, 1'b1);
        check_eq("reset_busy", bus_if.busy, 1'b1);
        check_eq("reset_ack", bus_if.ack, 1'b0);

        // Release after 3 reset cycles; edge 1 follows.
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Clear request sampled at edge 20.
        repeat (19) @(negedge clk);
        bus_if.req_clr = 1'b1;
        @(negedge clk);
        bus_if.req_clr = 1'b0;
        repeat (15) @(negedge clk);

        // Both requests together; preset held afterwards.
        bus_if.req_clr = 1'b1;
        bus_if.req_set = 1'b1;
        @(negedge clk);
        bus_if.req_clr = 1'b0;
        repeat (2 * H + 8) @(negedge clk);
        bus_if.req_set = 1'b0;
        repeat (H + 6) @(negedge clk);

        // Preset pulse during a clear hold is ignored.
        bus_if.req_clr = 1'b1;
        @(negedge clk);
        bus_if.req_clr = 1'b0;
        repeat (3) @(negedge clk);
        bus_if.req_set = 1'b1;
        @(negedge clk);
        bus_if.req_set = 1'b0;
        repeat (H + 6) @(negedge clk);

        // Reset in the middle of a preset hold acts without a clock edge.
        bus_if.req_set = 1'b1;
        @(negedge clk);
        bus_if.req_set = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rn", bus_if.rn, 1'b0);
        check_eq("async_setn", bus_if.setn, 1'b1);
        check_eq("async_busy", bus_if.busy, 1'b1);
        check_eq("async_ack", bus_if.ack, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (S + H + 4) @(negedge clk);

        // Randomized requests with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            bus_if.req_clr = ($urandom_range(0, 7) == 0);
            bus_if.req_set = ($urandom_range(0, 3) == 0);
            rst            = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst            = 1'b0;
        bus_if.req_clr = 1'b0;
        bus_if.req_set = 1'b0;
        repeat (2 * H + 2 * S + 8) @(negedge clk);

        // Preset request held for 50 cycles.
        bus_if.req_set = 1'b1;
        repeat (50) @(negedge clk);
        bus_if.req_set = 1'b0;
        repeat (H + 6) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rstset_release_seq.md
# rstset_release_seq

Clear/preset release sequencer that drives the RN and SETN pins of a bank of negative-edge async-clear/async-preset flops. It asserts the controls immediately on system reset and releases them synchronously after a programmable hold. It also runs handshaken software clear and preset pulses. All control edges are placed on the rising edge of CLK, half a cycle away from the downstream flops' falling capture edge. It sits between the chip reset tree and the 9-track negative-edge register banks.

## Interface
- SYNC_STAGES, 2: reset-deassertion synchronizer depth; legal values are 2 and above.
- HOLD_CYCLES, 8: cycles RN or SETN is held low per operation; legal range is 1 to 2^CNT_W−1.
- CNT_W, 4: hold counter width.
- CLK  in  1  clock; all state updates occur on the rising edge.
- RST  in  1  reset, asynchronous, active-high.
- REQ_CLR  in  1  software clear request, level-sampled in IDLE.
- REQ_SET  in  1  software preset request, level-sampled in IDLE.
- RN  out  1  active-low clear to the flop bank; registered.
- SETN  out  1  active-low preset to the flop bank; registered.
- BUSY  out  1  high whenever the state is not IDLE.
- ACK  out  1  one-cycle completion pulse for a software request.

## Operation
- Reset values: RN=0, SETN=1, BUSY=1, ACK=0, state=RST_HOLD, counter=0, synchronizer=0. RST forces these values asynchronously.
- RST_HOLD: the synchronizer shifts in 1 each cycle. When its output is 1, the counter counts up. When the count reaches HOLD_CYCLES−1, the block sets RN=1 and moves to IDLE.
- IDLE: BUSY=0.
  - REQ_CLR=1 moves to CLR_HOLD with RN=0. REQ_CLR has priority when both requests are high.
  - Otherwise REQ_SET=1 moves to SET_HOLD with SETN=0.
- CLR_HOLD / SET_HOLD: the counter runs 0..HOLD_CYCLES−1. At terminal count the active control returns to 1 and the state moves to GUARD.
- GUARD: one cycle with both controls inactive. Then the state moves to DONE.
- DONE: ACK=1 for exactly one cycle, then IDLE.
- Invariant: RN=0 and SETN=0 are never simultaneously low.
- Requests are ignored while BUSY=1. They are not queued. A request still high when the block returns to IDLE is accepted again.
- RST mid-operation: all outputs revert immediately to reset values, any pending ACK is lost, and the full RST_HOLD sequence reruns.
- Counter: unsigned, cleared on every state entry, never wraps. Terminal compare is at HOLD_CYCLES−1.

## Timing
- Edge 1 is the first rising CLK edge after RST falls.
  - The synchronizer output is 1 after edge SYNC_STAGES.
  - RN rises after edge SYNC_STAGES+HOLD_CYCLES.
  - With defaults this is edge 10; BUSY falls on the same edge.
- Software request sampled at edge k:
  - Control low: after k through k+HOLD_CYCLES.
  - GUARD: after k+HOLD_CYCLES+1.
  - ACK high: after k+HOLD_CYCLES+2, for one cycle.
  - IDLE and BUSY=0: after k+HOLD_CYCLES+3.
- Control outputs come directly from flops with no combinational path from inputs, so they are glitch-free.

## Configuration
- RSTSEQ_SETN_EN defined: the preset path is present, with SET_HOLD, REQ_SET honoured, and SETN driven.
- RSTSEQ_SETN_EN not defined:
  - SETN is tied to 1.
  - REQ_SET is ignored; the port remains.
  - The SET_HOLD state and its logic are removed.
  - The clear path is unchanged.

## Structure
- Package rstseq_pkg holds:
  - the state enum {RST_HOLD, IDLE, CLR_HOLD, SET_HOLD, GUARD, DONE}, binary encoded;
  - the CNT_W default and localparams for the hold terminal count.
- Sub-module rstseq_sync: a SYNC_STAGES-deep flop chain. It has async set-to-0 on RST, shifts in a constant 1, and outputs the last stage.
- The top level contains the FSM, the counter and the output registers.

## Test plan
- RST high for 3 cycles, then low → RN=0 through edge 9 and RN=1 after edge 10; SETN stays 1; BUSY falls after edge 10.
- In IDLE, REQ_CLR high at edge 20 → RN=0 after edges 20–28, ACK=1 after edge 30 only, BUSY=0 after edge 31.
- REQ_CLR and REQ_SET both high at the same edge → only RN pulses and SETN stays 1; with REQ_SET held, SET_HOLD starts immediately after returning to IDLE.
- REQ_SET pulsed during CLR_HOLD → ignored, so exactly one ACK is seen; RN and SETN are never both 0 on any cycle (checked by assertion).
- RST asserted mid-SET_HOLD → SETN=1 and RN=0 immediately (asynchronously), ACK never asserts, and the release repeats the 10-edge timing.
- Build without RSTSEQ_SETN_EN, REQ_SET held high for 50 cycles → SETN constant 1, BUSY stays 0, no ACK.
